// File: rtl/cfa_frame_sequencer.sv
// Frame-level controller for the CFA demosaic core: accepts and shadows the per-frame
// config, starts the core, counts write strobes to end of frame, drains, and recovers via hold.
module cfa_frame_sequencer #(
  parameter int unsigned rowBitWidth  = 11,
  parameter int unsigned colBitWidth  = 11,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned WDT_BW       = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic signed [rowBitWidth-1:0] cfg_rowMax,
  input  logic signed [colBitWidth-1:0] cfg_colMax,
  input  logic [1:0]                    cfg_pattern,
  input  logic [49:0]                   cfg_th,
  output logic signed [rowBitWidth-1:0] rowMax,
  output logic signed [colBitWidth-1:0] colMax,
  output logic [1:0]                    patternSelect,
  output logic [49:0]                   th,
  output logic                          core_start,
  output logic                          core_hold,
  input  logic                          wr_strobe,
  input  logic                          abort,
  input  logic                          irq_clear,
  output logic                          busy,
  output logic                          done_irq,
  output logic [2:0]                    status,
  output logic [21:0]                   pix_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE, S_FLUSH
  } state_t;

  localparam int unsigned CNT_MAX = (DRAIN_CYCLES > FLUSH_CYCLES) ? DRAIN_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WDT_BW-1:0] WDT_LAST   = {{(WDT_BW-1){1'b1}}, 1'b0};

  state_t                        r_state, w_next;
  logic [CNT_W-1:0]              r_cnt;
  logic [WDT_BW-1:0]             r_wdt;
  logic [21:0]                   r_total, r_pix;
  logic [2:0]                    r_status;
  logic                          r_irq;
  logic signed [rowBitWidth-1:0] r_rowMax;
  logic signed [colBitWidth-1:0] r_colMax;
  logic [1:0]                    r_pattern;
  logic [49:0]                   r_th;

  logic        w_cfg_bad, w_accept, w_cfg_err, w_pix_inc, w_set_irq, w_set_abort, w_set_tmo;
  logic [21:0] w_rows, w_cols;

  assign w_cfg_bad = cfg_rowMax[rowBitWidth-1] || (cfg_rowMax == '0) ||
                     cfg_colMax[colBitWidth-1] || (cfg_colMax == '0);
  assign w_rows    = 22'($unsigned(r_rowMax)) + 22'd1;
  assign w_cols    = 22'($unsigned(r_colMax)) + 22'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_cfg_err   = 1'b0;
    w_pix_inc   = 1'b0;
    w_set_irq   = 1'b0;
    w_set_abort = 1'b0;
    w_set_tmo   = 1'b0;
    cfg_ready   = 1'b0;
    busy        = 1'b1;
    core_start  = 1'b0;
    core_hold   = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) begin
          if (w_cfg_bad) begin
            w_cfg_err = 1'b1;
            w_set_irq = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_LOAD;
          end
        end
      end
      S_LOAD:  w_next = S_START;
      S_START: begin
        core_start = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        if (wr_strobe) begin
          if (r_pix != r_total) w_pix_inc = 1'b1;
          if (r_pix + 22'd1 == r_total) w_next = S_DRAIN;
        end else if (r_wdt == WDT_LAST) begin
          w_set_tmo = 1'b1;
          w_next    = S_FLUSH;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_next    = S_DONE;
          w_set_irq = 1'b1;
        end
      end
      S_FLUSH: begin
        core_hold = 1'b1;
        if (r_cnt == FLUSH_LAST) begin
          w_next    = S_IDLE;
          w_set_irq = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides every other transition but leaves the strobe count update intact.
    if (abort && (r_state inside {S_LOAD, S_START, S_RUN, S_DRAIN})) begin
      w_set_abort = 1'b1;
      w_set_tmo   = 1'b0;
      w_set_irq   = 1'b0;
      w_next      = S_FLUSH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wdt     <= '0;
      r_total   <= '0;
      r_pix     <= '0;
      r_status  <= '0;
      r_irq     <= 1'b0;
      r_rowMax  <= '0;
      r_colMax  <= '0;
      r_pattern <= '0;
      r_th      <= '0;
    end else begin
      if (w_next != r_state)                      r_cnt <= '0;
      else if (r_state inside {S_DRAIN, S_FLUSH}) r_cnt <= r_cnt + 1'b1;

      if (r_state == S_RUN && !wr_strobe) r_wdt <= r_wdt + 1'b1;
      else                                r_wdt <= '0;

      if (r_state == S_LOAD) r_total <= w_rows * w_cols;

      if (w_accept) begin
        r_rowMax  <= cfg_rowMax;
        r_colMax  <= cfg_colMax;
        r_pattern <= cfg_pattern;
        r_th      <= cfg_th;
        r_status  <= '0;
        r_pix     <= '0;
      end else begin
        if (w_cfg_err)   r_status[0] <= 1'b1;
        if (w_set_abort) r_status[1] <= 1'b1;
        if (w_set_tmo)   r_status[2] <= 1'b1;
        if (w_pix_inc)   r_pix       <= r_pix + 22'd1;
      end

      if (w_set_irq)      r_irq <= 1'b1;
      else if (irq_clear) r_irq <= 1'b0;
    end
  end

  assign rowMax        = r_rowMax;
  assign colMax        = r_colMax;
  assign patternSelect = r_pattern;
  assign th            = r_th;
  assign done_irq      = r_irq;
  assign status        = r_status;
  assign pix_cnt       = r_pix;

endmodule

// File: tb/tb_cfa_frame_sequencer.sv
// Directed bench for cfa_frame_sequencer: vector table for the main frame flow plus
// hand-written abort, watchdog and async-reset sequences. Watchdog shortened to 4 bits.
module tb_cfa_frame_sequencer;
  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid, cfg_ready;
  logic signed [10:0] cfg_rowMax, cfg_colMax, rowMax, colMax;
  logic [1:0]         cfg_pattern, patternSelect;
  logic [49:0]        cfg_th, th;
  logic               core_start, core_hold, wr_strobe, abort, irq_clear, busy, done_irq;
  logic [2:0]         status;
  logic [21:0]        pix_cnt;

  localparam logic [49:0] TH = 50'h2_3456_789A_BCDE;

  cfa_frame_sequencer #(
    .rowBitWidth(11), .colBitWidth(11), .DRAIN_CYCLES(3), .FLUSH_CYCLES(4), .WDT_BW(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_rowMax(cfg_rowMax), .cfg_colMax(cfg_colMax), .cfg_pattern(cfg_pattern),
    .cfg_th(cfg_th), .rowMax(rowMax), .colMax(colMax), .patternSelect(patternSelect),
    .th(th), .core_start(core_start), .core_hold(core_hold), .wr_strobe(wr_strobe),
    .abort(abort), .irq_clear(irq_clear), .busy(busy), .done_irq(done_irq),
    .status(status), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [10:0] rm, cm;
    logic [1:0]  pat;
    logic        st, ab, clr;
    logic        e_rdy, e_start, e_hold, e_busy, e_irq;
    logic [2:0]  e_status;
    logic [21:0] e_pix;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tv[18];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] rm, input logic [10:0] cm,
                       input logic [1:0] pat, input logic st, input logic ab, input logic clr);
    cfg_valid   = v;
    cfg_rowMax  = rm;
    cfg_colMax  = cm;
    cfg_pattern = pat;
    wr_strobe   = st;
    abort       = ab;
    irq_clear   = clr;
  endtask

  task automatic idle();
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_idle(input int unsigned n);
    idle();
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic accept(input logic [10:0] rm, input logic [10:0] cm);
    drive(1'b1, rm, cm, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  task automatic strobes(input int unsigned n);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int unsigned k = 0; k < n; k++) tick();
    idle();
  endtask

  initial begin
    cfg_th = TH;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", cfg_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.irq", done_irq, 0);
    chk("rst.status", status, 0);
    chk("rst.th", th, 0);
    rst = 1'b0;

    //          v     rm      cm      pat   st    ab    clr   rdy   start hold  busy  irq   status  pix
    tv[0]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 22'd0};
    tv[1]  = '{1'b1, 11'd0, 11'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 22'd0};
    tv[2]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 22'd0};
    tv[3]  = '{1'b1, 11'd1, 11'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd0};
    tv[4]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 22'd0};
    tv[5]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd0};
    tv[6]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd1};
    tv[7]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd1};
    tv[8]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd2};
    tv[9]  = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd3};
    tv[10] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd4};
    tv[11] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd4};
    tv[12] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd4};
    tv[13] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 22'd4};
    tv[14] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 22'd4};
    tv[15] = '{1'b1, 11'd2, 11'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 22'd0};
    tv[16] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 22'd0};
    tv[17] = '{1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 22'd0};

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].v, tv[i].rm, tv[i].cm, tv[i].pat, tv[i].st, tv[i].ab, tv[i].clr);
      tick();
      chk($sformatf("v%0d.rdy", i), cfg_ready, tv[i].e_rdy);
      chk($sformatf("v%0d.start", i), core_start, tv[i].e_start);
      chk($sformatf("v%0d.hold", i), core_hold, tv[i].e_hold);
      chk($sformatf("v%0d.busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d.irq", i), done_irq, tv[i].e_irq);
      chk($sformatf("v%0d.status", i), status, tv[i].e_status);
      chk($sformatf("v%0d.pix", i), pix_cnt, tv[i].e_pix);
      if (i == 3) begin
        chk("shadow.rowMax", rowMax, 1);
        chk("shadow.colMax", colMax, 1);
        chk("shadow.pattern", patternSelect, 2);
        chk("shadow.th", th, TH);
      end
    end

    // Frame of 9 in RUN: final strobe together with abort, irq_clear on the FLUSH exit cycle.
    strobes(8);
    chk("ab9.pix8", pix_cnt, 8);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ab9.pix", pix_cnt, 9);
    chk("ab9.hold", core_hold, 1);
    chk("ab9.status", status, 3'b010);
    for (int unsigned k = 0; k < 3; k++) begin
      tick_idle(1);
      chk($sformatf("ab9.hold%0d", k), core_hold, 1);
    end
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ab9.hold_end", core_hold, 0);
    chk("ab9.idle_rdy", cfg_ready, 1);
    chk("ab9.irq_set_wins", done_irq, 1);
    chk("ab9.rowMax_kept", rowMax, 2);
    tick();
    chk("irq_clear", done_irq, 0);

    // Abort after 5 of 16 strobes.
    accept(11'd3, 11'd3);
    chk("ab5.status_clr", status, 0);
    tick_idle(2);
    strobes(5);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("ab5.hold", core_hold, 1);
    tick_idle(3);
    chk("ab5.hold4", core_hold, 1);
    tick_idle(1);
    chk("ab5.hold_end", core_hold, 0);
    chk("ab5.status", status, 3'b010);
    chk("ab5.pix", pix_cnt, 5);
    chk("ab5.irq", done_irq, 1);
    chk("ab5.rdy", cfg_ready, 1);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Watchdog: 15 idle RUN cycles with a 4-bit watchdog.
    accept(11'd3, 11'd3);
    tick_idle(2);
    tick_idle(14);
    chk("wdt.hold14", core_hold, 0);
    chk("wdt.busy14", busy, 1);
    tick_idle(1);
    chk("wdt.hold15", core_hold, 1);
    chk("wdt.status", status, 3'b100);
    tick_idle(4);
    chk("wdt.rdy", cfg_ready, 1);
    chk("wdt.irq", done_irq, 1);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Negative colMax rejected.
    drive(1'b1, 11'd3, 11'h7FF, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("neg.status", status, 3'b101);
    chk("neg.irq", done_irq, 1);
    chk("neg.busy", busy, 0);
    drive(1'b0, 11'd0, 11'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();

    // Asynchronous reset mid-RUN.
    accept(11'd3, 11'd3);
    tick_idle(2);
    strobes(2);
    chk("arst.pix_pre", pix_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst.pix", pix_cnt, 0);
    chk("arst.rdy", cfg_ready, 1);
    chk("arst.busy", busy, 0);
    chk("arst.rowMax", rowMax, 0);
    chk("arst.th", th, 0);
    #3 rst = 1'b0;
    tick_idle(1);
    chk("arst.after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
